// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one sync data memory between CPU (m0) and debug (m1).
// Optional ARB_LOCK_EN: m1_lock keeps port 1 on top for a burst.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          m1_lock,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflict_cnt
);

  logic          r_last;
  logic          r_rd_pend;
  logic          r_rd_port;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          w_lock_win;
  logic          w_pick1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any;

`ifdef ARB_LOCK_EN
  logic r_lock;

  assign w_lock_win = r_lock & m1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock <= 1'b0;
    end else if (!m1_req) begin
      r_lock <= 1'b0;
    end else if (w_gnt1) begin
      r_lock <= m1_lock;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = m1_lock;
  assign w_lock_win    = 1'b0;
`endif

  // On a tie, the port that did not go last wins
  assign w_pick1 = m1_req & (~m0_req | ~r_last | w_lock_win);
  assign w_gnt1  = ~rst & w_pick1;
  assign w_gnt0  = ~rst & m0_req & ~w_pick1;
  assign w_any   = w_gnt0 | w_gnt1;

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  always_comb begin
    mem_en    = w_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_rvalid    = r_rd_pend & ~r_rd_port;
  assign m1_rvalid    = r_rd_pend & r_rd_port;
  assign m0_rdata     = m0_rvalid ? mem_rdata : r_m0_rdata;
  assign m1_rdata     = m1_rvalid ? mem_rdata : r_m1_rdata;
  assign conflict_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_port  <= 1'b0;
      r_cnt      <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      if (w_any) begin
        r_last <= w_gnt1;
      end
      r_rd_pend <= w_any & ~mem_we;
      if (w_any & ~mem_we) begin
        r_rd_port <= w_gnt1;
      end
      if (m0_rvalid) begin
        r_m0_rdata <= mem_rdata;
      end
      if (m1_rvalid) begin
        r_m1_rdata <= mem_rdata;
      end
      if (m0_req & m1_req & (r_cnt != {CW{1'b1}})) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, read routing, counter and lock.
// A second instance with CW=4 shares the stimulus to observe saturation.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   conflict_cnt;

  logic          s_m0_gnt, s_m1_gnt, s_m0_rvalid, s_m1_rvalid;
  logic [DW-1:0] s_m0_rdata, s_m1_rdata;
  logic          s_mem_en, s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic [3:0]    s_cnt;

  logic [DW-1:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .CW(4)) dut_s (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
    .m1_lock(m1_lock),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(s_cnt)
  );

  // Single-port synchronous memory, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    m1_lock = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    m0_req = 1; m0_addr = 8'h01;
    m1_req = 1; m1_addr = 8'h02;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL rst_gnt cyc%0d: got %b%b want 00", i, m0_gnt, m1_gnt);
      end
      checks++;
      if (mem_en !== 1'b0) begin
        errors++;
        $display("FAIL rst_mem_en cyc%0d: got %b want 0", i, mem_en);
      end
      checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL rst_rvalid cyc%0d: got %b%b want 00", i, m0_rvalid, m1_rvalid);
      end
      checks++;
      if (conflict_cnt !== 16'd0 || m0_rdata !== 32'd0) begin
        errors++;
        $display("FAIL rst_state cyc%0d: cnt %0d rdata %h want 0 0", i, conflict_cnt, m0_rdata);
      end
    end
    rst = 0;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_tie: gnt %b%b en %b want 10 1", m0_gnt, m1_gnt, mem_en);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 8'h05;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || mem_addr !== 8'h05 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt: gnt %b addr %h we %b want 1 05 0", m0_gnt, mem_addr, mem_we);
    end
    step();
    m0_req = 0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678 || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid: rv %b%b data %h want 10 12345678", m0_rvalid, m1_rvalid, m0_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL single_hold: rv %b data %h want 0 12345678", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_contention();
    logic exp1;
    logic prev;
    do_reset();
    m0_req = 1; m0_addr = 8'h01;
    m1_req = 1; m1_addr = 8'h02;
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      exp1 = (i % 2) == 1;
      @(negedge clk);
      checks++;
      if (m0_gnt !== !exp1 || m1_gnt !== exp1) begin
        errors++;
        $display("FAIL cont_gnt cyc%0d: got %b%b want %b%b", i, m0_gnt, m1_gnt, !exp1, exp1);
      end
      if (i > 0) begin
        checks++;
        if (m0_rvalid !== !prev || m1_rvalid !== prev ||
            (!prev && m0_rdata !== 32'hA5000001) ||
            (prev && m1_rdata !== 32'hA5000002)) begin
          errors++;
          $display("FAIL cont_rd cyc%0d: rv %b%b d0 %h d1 %h prev %b",
                   i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, prev);
        end
      end
      prev = exp1;
      step();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hA5000002) begin
      errors++;
      $display("FAIL cont_last_rd: rv %b%b d1 %h want 01 a5000002", m0_rvalid, m1_rvalid, m1_rdata);
    end
    checks++;
    if (conflict_cnt !== 16'd6) begin
      errors++;
      $display("FAIL cont_cnt: got %0d want 6", conflict_cnt);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 8'h10; m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 ||
        mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_issue: gnt %b we %b addr %h wd %h", m1_gnt, mem_we, mem_addr, mem_wdata);
    end
    step();
    idle_inputs();
    m0_req = 1; m0_addr = 8'h10;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wr_no_rvalid: rv %b%b gnt0 %b want 00 1", m0_rvalid, m1_rvalid, m0_gnt);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_readback: rv %b data %h want 1 deadbeef", m0_rvalid, m0_rdata);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_bus: en %b we %b addr %h wd %h want 0 0 00 0",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      if (i <= 3) begin
        m0_req = 1; m0_addr = AW'(i);
      end else begin
        idle_inputs();
      end
      exp_d = 32'hA5000000 + (i - 1);
      @(negedge clk);
      checks++;
      if (m0_gnt !== (i <= 3) || (i > 1 && (m0_rvalid !== 1'b1 || m0_rdata !== exp_d))) begin
        errors++;
        $display("FAIL b2b cyc%0d: gnt %b rv %b data %h want %b 1 %h",
                 i, m0_gnt, m0_rvalid, m0_rdata, (i <= 3), exp_d);
      end
      step();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    m0_req = 1; m0_addr = 8'h01;
    m1_req = 1; m1_addr = 8'h02;
    repeat (14) step();
    @(negedge clk);
    checks++;
    if (s_cnt !== 4'd14) begin
      errors++;
      $display("FAIL sat_pre: got %0d want 14", s_cnt);
    end
    repeat (6) step();
    @(negedge clk);
    checks++;
    if (s_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: got %0d want 15", s_cnt);
    end
    checks++;
    if (conflict_cnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_wide: got %0d want 20", conflict_cnt);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_midread();
    do_reset();
    step();
    m0_req = 1; m0_addr = 8'h05;
    step();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_midread: rv %b%b data %h want 00 0", m0_rvalid, m1_rvalid, m0_rdata);
    end
  endtask

  task automatic test_lock();
    logic [4:0] exp1;
`ifdef ARB_LOCK_EN
    exp1 = 5'b01110;
`else
    exp1 = 5'b01010;
`endif
    do_reset();
    m0_req = 1; m0_addr = 8'h01;
    m1_req = 1; m1_addr = 8'h02; m1_lock = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        m1_req = 0; m1_lock = 0;
      end
      @(negedge clk);
      checks++;
      if (m1_gnt !== exp1[4-i] || m0_gnt !== !exp1[4-i]) begin
        errors++;
        $display("FAIL lock_gnt cyc%0d: got %b%b want %b%b",
                 i, m0_gnt, m1_gnt, !exp1[4-i], exp1[4-i]);
      end
      step();
    end
    checks++;
    if (conflict_cnt !== 16'd4) begin
      errors++;
      $display("FAIL lock_cnt: got %0d want 4", conflict_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 + i;
    mem[5] = 32'h12345678;
    mem_rdata = '0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_saturation();
    test_reset_midread();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
